// File: rtl/riviera_fetch_pkg.sv
// Shared types for the instruction fetch stage.
// Queue entries pair an instruction with its byte PC.
package riviera_fetch_pkg;

   localparam int INSTR_WIDTH = 32;
   localparam int PC_W        = 32;

   typedef struct packed {
      logic [PC_W-1:0]        pc;
      logic [INSTR_WIDTH-1:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      BOOT,
      RUN
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode valid/ready handshake.
// master drives the instruction, slave returns ready.
interface fetch_unit_if
   import riviera_fetch_pkg::*;
#(
   parameter int PC_WIDTH = 32
);
   logic                   o_valid;
   logic                   i_ready;
   logic [INSTR_WIDTH-1:0] o_instr;
   logic [PC_WIDTH-1:0]    o_pc;

   modport master (
      output o_valid,
      output o_instr,
      output o_pc,
      input  i_ready
   );

   modport slave (
      input  o_valid,
      input  o_instr,
      input  o_pc,
      output i_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction FIFO: up to two pushes and one pop per cycle,
// flush clears it; head reads as zero when empty.
module fetch_queue
   import riviera_fetch_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push0,
   input  logic                       push1,
   input  fetch_entry_t               d0,
   input  fetch_entry_t               d1,
   input  logic                       pop,
   output fetch_entry_t               head,
   output logic [$clog2(QDEPTH):0]    count
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t  mem [QDEPTH];
   logic [PW-1:0] rp;
   logic [PW-1:0] wp;

   assign head = (count != '0) ? mem[rp] : '0;

   always_ff @(posedge clk) begin
      if (push0)
         mem[wp] <= d0;
      if (push1)
         mem[wp + PW'(1)] <= d1;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rp    <= '0;
         wp    <= '0;
         count <= '0;
      end else begin
         rp    <= rp + PW'(pop);
         wp    <= wp + PW'(push0) + PW'(push1);
         count <= count + CW'(push0) + CW'(push1) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush)
         assert (int'(count) + int'(push0) + int'(push1)
                 - int'(pop) <= QDEPTH);
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, instr_mem addressing, 64->2x32 split, queue.
// Optional FETCH_STATS_EN adds word/bubble/redirect counters.
module fetch_unit
   import riviera_fetch_pkg::*;
#(
   parameter int PC_WIDTH   = 32,
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 64,
   parameter int QDEPTH     = 4,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] o_imem_addr,
   input  logic [DATA_WIDTH-1:0] i_imem_rdata,
   input  logic                  i_redirect,
   input  logic [PC_WIDTH-1:0]   i_redirect_pc,
`ifdef FETCH_STATS_EN
   output logic [31:0]           o_stat_words,
   output logic [31:0]           o_stat_bubbles,
   output logic [31:0]           o_stat_redirects,
`endif
   fetch_unit_if.master          dec
);

   localparam int CW = $clog2(QDEPTH) + 1;
   localparam logic [CW:0] ISSUE_LIM = (CW+1)'(QDEPTH - 2);

   fetch_state_e          state;
   fetch_state_e          state_nxt;
   logic [PC_WIDTH-1:0]   fpc;
   logic [PC_WIDTH-1:0]   inflight_pc;
   logic                  inflight;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  issue;
   logic                  ret;
   logic                  pop;
   logic                  push1;
   logic [CW-1:0]         q_count;
   logic [CW:0]           need;
   logic [31:0]           lo;
   logic [31:0]           hi;
   fetch_entry_t          d0;
   fetch_entry_t          d1;
   fetch_entry_t          head;
   logic                  unused_bits;

   assign unused_bits = &i_redirect_pc[1:0];

   // Each outstanding word may still land two entries.
   assign need = {1'b0, q_count}
               + {{(CW-1){1'b0}}, inflight, 1'b0};

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      unique case (state)
         BOOT: state_nxt = RUN;
         RUN:  issue = !i_redirect && (need <= ISSUE_LIM);
      endcase
   end

   assign ret   = inflight && !i_redirect;
   assign push1 = ret && !inflight_pc[2];
   assign pop   = dec.o_valid && dec.i_ready && !i_redirect;

   assign lo = i_imem_rdata[31:0];
   assign hi = i_imem_rdata[63:32];
   assign d0 = '{pc: inflight_pc,
                 instr: inflight_pc[2] ? hi : lo};
   assign d1 = '{pc: inflight_pc + PC_WIDTH'(4), instr: hi};

   assign o_imem_addr = issue ? fpc[ADDR_WIDTH+2:3] : addr_q;

   always_ff @(posedge clk) begin
      if (rst)
         state <= BOOT;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc         <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= RESET_PC;
         addr_q      <= RESET_PC[ADDR_WIDTH+2:3];
      end else begin
         addr_q   <= o_imem_addr;
         inflight <= issue;
         if (issue) begin
            inflight_pc <= fpc;
            fpc <= {fpc[PC_WIDTH-1:3] + (PC_WIDTH-3)'(1), 3'b0};
         end
         if (i_redirect)
            fpc <= {i_redirect_pc[PC_WIDTH-1:2], 2'b0};
      end
   end

   fetch_queue #(
      .QDEPTH (QDEPTH)
   ) u_queue (
      .clk   (clk),
      .rst   (rst),
      .flush (i_redirect),
      .push0 (ret),
      .push1 (push1),
      .d0    (d0),
      .d1    (d1),
      .pop   (pop),
      .head  (head),
      .count (q_count)
   );

   assign dec.o_valid = (q_count != '0);
   assign dec.o_instr = head.instr;
   assign dec.o_pc    = head.pc;

`ifdef FETCH_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         o_stat_words     <= '0;
         o_stat_bubbles   <= '0;
         o_stat_redirects <= '0;
      end else begin
         if (ret)
            o_stat_words <= o_stat_words + 32'd1;
         if (state == RUN && !dec.o_valid)
            o_stat_bubbles <= o_stat_bubbles + 32'd1;
         if (i_redirect)
            o_stat_redirects <= o_stat_redirects + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a PC-stream model.
// Define FETCH_STATS_EN to also check the statistics counters.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] imem_addr;
   logic [63:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [63:0] mem [2048];

   int n_checks;
   int n_fail;

   always #5 clk = ~clk;

   always_ff @(posedge clk)
      imem_rdata <= mem[imem_addr];

   fetch_unit_if #(.PC_WIDTH(32)) dec_if ();

`ifdef FETCH_STATS_EN
   logic [31:0] st_w;
   logic [31:0] st_b;
   logic [31:0] st_r;
`endif

   fetch_unit dut (
      .clk              (clk),
      .rst              (rst),
      .o_imem_addr      (imem_addr),
      .i_imem_rdata     (imem_rdata),
      .i_redirect       (redirect),
      .i_redirect_pc    (redirect_pc),
`ifdef FETCH_STATS_EN
      .o_stat_words     (st_w),
      .o_stat_bubbles   (st_b),
      .o_stat_redirects (st_r),
`endif
      .dec              (dec_if)
   );

   function automatic logic [31:0] ref_instr(logic [31:0] pc);
      logic [63:0] w;
      w = mem[pc[13:3]];
      return pc[2] ? w[63:32] : w[31:0];
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_instr(string tag, logic [31:0] pc);
      chk({tag, "_v"}, 64'(dec_if.o_valid), 64'd1);
      chk({tag, "_pc"}, 64'(dec_if.o_pc), 64'(pc));
      chk({tag, "_in"}, 64'(dec_if.o_instr), 64'(ref_instr(pc)));
   endtask

   task automatic chk_bubble(string tag);
      chk(tag, 64'(dec_if.o_valid), 64'd0);
   endtask

   // One cycle: drive just after the edge, return at the falling edge.
   task automatic cyc(bit rs, bit rdy, bit rd, logic [31:0] tgt);
      @(posedge clk);
      #1;
      rst            = rs;
      dec_if.i_ready = rdy;
      redirect       = rd;
      redirect_pc    = tgt;
      @(negedge clk);
   endtask

   // Cycles 0..3 after reset release with ready held high.
   task automatic boot_seq(string tag);
      cyc(0, 1, 0, '0);
      chk({tag, "_c0_v"}, 64'(dec_if.o_valid), 64'd0);
      chk({tag, "_c0_in"}, 64'(dec_if.o_instr), 64'd0);
      chk({tag, "_c0_pc"}, 64'(dec_if.o_pc), 64'd0);
      chk({tag, "_c0_ad"}, 64'(imem_addr), 64'd0);
      cyc(0, 1, 0, '0);
      chk_bubble({tag, "_c1"});
      chk({tag, "_c1_ad"}, 64'(imem_addr), 64'd0);
      cyc(0, 1, 0, '0);
      chk_bubble({tag, "_c2"});
      cyc(0, 1, 0, '0);
      chk_instr({tag, "_c3"}, 32'h0);
      chk({tag, "_c3_k"}, 64'(dec_if.o_instr), 64'h00100093);
   endtask

   logic [31:0] t;
   logic [31:0] exp_pc;
   logic [31:0] prev_pc;
   logic [31:0] prev_in;
   logic [31:0] tgt;
   int          since_rd;
   bit          prev_stall;
   bit          rdy;
   bit          rd;

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      rst            = 1'b1;
      redirect       = 1'b0;
      redirect_pc    = '0;
      dec_if.i_ready = 1'b0;
      foreach (mem[i]) mem[i] = {$urandom, $urandom};
      mem[0] = 64'h00200093_00100093;

      repeat (3) cyc(1, 1, 0, '0);
      chk("rst_v", 64'(dec_if.o_valid), 64'd0);
      chk("rst_in", 64'(dec_if.o_instr), 64'd0);
      chk("rst_pc", 64'(dec_if.o_pc), 64'd0);
      chk("rst_ad", 64'(imem_addr), 64'd0);

      boot_seq("t1");
      cyc(0, 1, 0, '0);
      chk_instr("t1_c4", 32'h4);
      chk("t1_c4_k", 64'(dec_if.o_instr), 64'h00200093);
      for (int k = 2; k < 16; k++) begin
         cyc(0, 1, 0, '0);
         chk_instr("t1_stream", 32'(4 * k));
      end

      cyc(0, 1, 1, 32'h1C);
      cyc(0, 1, 0, '0);
      chk_bubble("rd_r1");
      chk("rd_r1_ad", 64'(imem_addr), 64'd3);
      cyc(0, 1, 0, '0);
      chk_bubble("rd_r2");
      cyc(0, 1, 0, '0);
      chk_instr("rd_r3", 32'h1C);
      cyc(0, 1, 0, '0);
      chk_instr("rd_r4", 32'h20);
      cyc(0, 1, 0, '0);
      chk_instr("rd_r5", 32'h24);

      // Two stream phases so one redirect lands on a returning word.
      for (int ph = 0; ph < 2; ph++) begin
         t = 32'h103 + 32'(ph * 64);
         repeat (ph + 2) cyc(0, 1, 0, '0);
         cyc(0, 1, 1, t);
         cyc(0, 1, 0, '0);
         chk_bubble("col_r1");
         cyc(0, 1, 0, '0);
         chk_bubble("col_r2");
         for (int k = 0; k < 6; k++) begin
            cyc(0, 1, 0, '0);
            chk_instr("col_seq", (t & ~32'h3) + 32'(4 * k));
         end
      end

      cyc(1, 0, 0, '0);
      cyc(1, 0, 0, '0);
      for (int c = 0; c < 10; c++) begin
         cyc(0, 0, 0, '0);
         if (c < 3) chk_bubble("fill_b");
         else chk_instr("fill_hold", 32'h0);
         if (c >= 2) chk("fill_ad", 64'(imem_addr), 64'd1);
      end
      for (int k = 0; k < 16; k++) begin
         cyc(0, 1, 0, '0);
         chk_instr("fill_rel", 32'(4 * k));
      end

      cyc(1, 1, 0, '0);
      boot_seq("p0");
      cyc(1, 1, 0, '0);
      chk_instr("pulse_c4", 32'h4);
      boot_seq("p1");
      cyc(0, 1, 0, '0);
      chk_instr("p1_c4", 32'h4);

      exp_pc     = 32'h8;
      since_rd   = 100;
      prev_stall = 1'b0;
      prev_pc    = '0;
      prev_in    = '0;
      for (int i = 0; i < 400; i++) begin
         rdy = ($urandom % 4) != 0;
         rd  = ($urandom % 20) == 0;
         tgt = $urandom_range(0, 16383);
         cyc(0, rdy, rd, tgt);
         since_rd++;
         if (since_rd == 1 || since_rd == 2)
            chk_bubble("rnd_gap");
         else if (since_rd == 3)
            chk("rnd_r3_v", 64'(dec_if.o_valid), 64'd1);
         if (prev_stall) begin
            chk("rnd_hold_v", 64'(dec_if.o_valid), 64'd1);
            chk("rnd_hold_pc", 64'(dec_if.o_pc), 64'(prev_pc));
            chk("rnd_hold_in", 64'(dec_if.o_instr), 64'(prev_in));
         end
         if (dec_if.o_valid && since_rd >= 3) begin
            chk_instr("rnd", exp_pc);
            if (rdy && !rd) exp_pc = exp_pc + 32'h4;
         end
         if (rd) begin
            exp_pc     = tgt & ~32'h3;
            since_rd   = 0;
            prev_stall = 1'b0;
         end else begin
            prev_stall = dec_if.o_valid && !rdy;
            prev_pc    = dec_if.o_pc;
            prev_in    = dec_if.o_instr;
         end
      end

`ifdef FETCH_STATS_EN
      // Stalled decode: each fill lands QDEPTH/2 words, then fetch idles.
      cyc(1, 0, 0, '0);
      for (int c = 0; c < 20; c++)
         cyc(0, 0, c == 10, '0);
      cyc(0, 0, 0, '0);
      chk("st_redirects", 64'(st_r), 64'd1);
      chk("st_words", 64'(st_w), 64'd4);
      chk("st_bubbles", 64'(st_b), 64'd4);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
